// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the count-register width helper.
package serial_ripple_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0..w-1, never less than one.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: diff = x - y - bi, bo = borrow out.
// Purely combinational.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor D = A - B - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, res_q, d_q;
    logic             br_q, bout_q;
    logic [CW-1:0]    cnt_q;
    logic             diff, nbr, last;

    assign last = (cnt_q == CW'(WIDTH - 1));

    full_subtractor u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bi   (br_q),
        .diff (diff),
        .bo   (nbr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (done_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == IDLE);
        done_valid  = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q   <= '0;
            sb_q   <= '0;
            res_q  <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        sa_q  <= a;
                        sb_q  <= b;
                        br_q  <= bin;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    res_q <= {diff, res_q[WIDTH-1:1]};
                    br_q  <= nbr;
                    cnt_q <= cnt_q + CW'(1);
                    // Outputs only move on entry to DONE, so they hold afterwards.
                    if (last) begin
                        d_q    <= {diff, res_q[WIDTH-1:1]};
                        bout_q <= nbr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign d    = d_q;
    assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && start_valid) begin
                a_msb_q <= a[WIDTH-1];
                b_msb_q <= b[WIDTH-1];
            end
            if (state_q == RUN && last) begin
                ovf_q <= (a_msb_q != b_msb_q) && (diff != a_msb_q);
            end
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4).
// Reference results come from plain integer arithmetic.
module tb_serial_ripple_subtractor;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic [W-1:0] d;
    logic         bout;
    logic         done_valid;
    logic         done_ready = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .bin         (bin),
        .d           (d),
        .bout        (bout),
`ifdef SERIAL_SUB_OVF_EN
        .ovf         (ovf),
`endif
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_d(input int x, input int y, input int bi);
        return (x - y - bi) & MASK;
    endfunction

    function automatic int ref_bout(input int x, input int y, input int bi);
        return (x < y + bi) ? 1 : 0;
    endfunction

    function automatic int ref_ovf(input int x, input int y, input int bi);
        int sx, sy, r;
        sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
        r = sx - sy - bi;
        return (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (start_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_wait", {31'd0, start_ready}, 32'd1);
    endtask

    // After the accept edge: WIDTH-1 busy edges, then DONE, hold, handshake.
    task automatic finish_op(input int x, input int y, input int bi,
                             input int hold);
        int ed, eb;
        ed = ref_d(x, y, bi);
        eb = ref_bout(x, y, bi);
        for (int k = 1; k < W; k++) begin
            @(posedge clk);
            #1;
            chk("busy_dv", {31'd0, done_valid}, 32'd0);
            chk("busy_sr", {31'd0, start_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("done_dv", {31'd0, done_valid}, 32'd1);
        chk("d", {28'd0, d}, ed);
        chk("bout", {31'd0, bout}, eb);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", {31'd0, ovf}, ref_ovf(x, y, bi));
`endif
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk("hold_dv", {31'd0, done_valid}, 32'd1);
            chk("hold_d", {28'd0, d}, ed);
            chk("hold_bout", {31'd0, bout}, eb);
        end
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        chk("post_dv", {31'd0, done_valid}, 32'd0);
        chk("post_sr", {31'd0, start_ready}, 32'd1);
        chk("post_d", {28'd0, d}, ed);
        chk("post_bout", {31'd0, bout}, eb);
    endtask

    task automatic accept(input int x, input int y, input int bi);
        wait_idle();
        @(negedge clk);
        a = W'(x);
        b = W'(y);
        bin = bi[0];
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic run_op(input int x, input int y, input int bi,
                          input int hold);
        accept(x, y, bi);
        finish_op(x, y, bi, hold);
    endtask

    initial begin
        int x, y, bi;
        rst = 1'b1;
        #12;
        chk("rst_sr", {31'd0, start_ready}, 32'd1);
        chk("rst_dv", {31'd0, done_valid}, 32'd0);
        chk("rst_d", {28'd0, d}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op(9, 3, 0, 0);
        run_op(3, 9, 0, 0);
        run_op(0, 0, 1, 0);
        run_op(5, 5, 0, 3);
        run_op(15, 15, 1, 1);
        run_op(15, 0, 0, 0);

        // Asynchronous reset two cycles into RUN.
        accept(12, 5, 1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sr", {31'd0, start_ready}, 32'd1);
        chk("arst_dv", {31'd0, done_valid}, 32'd0);
        chk("arst_d", {28'd0, d}, 32'd0);
        chk("arst_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            chk("arst_nodone", {31'd0, done_valid}, 32'd0);
        end
        run_op(7, 2, 0, 0);

        // start_valid during RUN is ignored.
        accept(10, 4, 0);
        @(negedge clk);
        a = W'(1);
        b = W'(8);
        bin = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (W - 2) @(posedge clk);
        @(posedge clk);
        #1;
        chk("ign_dv", {31'd0, done_valid}, 32'd1);
        chk("ign_d", {28'd0, d}, ref_d(10, 4, 0));

        // Handshake coincident with start_valid: accepted one cycle later.
        @(negedge clk);
        done_ready = 1'b1;
        start_valid = 1'b1;
        a = W'(6);
        b = W'(11);
        bin = 1'b0;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        chk("coin_sr", {31'd0, start_ready}, 32'd1);
        chk("coin_dv", {31'd0, done_valid}, 32'd0);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        chk("coin_acc", {31'd0, start_ready}, 32'd0);
        finish_op(6, 11, 0, 0);

`ifdef SERIAL_SUB_OVF_EN
        run_op(8, 1, 0, 0);
        run_op(7, 1, 0, 0);
        run_op(8, 0, 1, 0);
`endif

        for (int i = 0; i < 20; i++) begin
            x = int'($urandom_range(MASK, 0));
            y = int'($urandom_range(MASK, 0));
            bi = int'($urandom_range(1, 0));
            run_op(x, y, bi, int'($urandom_range(2, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
